mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback over a single shared instruction/data memory port with a req/ready handshake.
- Drives PC/IR/register-file write enables and ALU/PC/writeback mux selects; the immediate generator decodes the IR independently.
- Also counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 86 ++++++++
 rtl/mc_ctrl_decode.sv | 109 ++++++++++
 rtl/mc_ctrl.sv | 106 ++++++++++
 tb/tb_mc_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM states,
// datapath mux encodings and the control vector driven by mc_ctrl_decode.
package mc_ctrl_pkg;

  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_ARITH_R = 7'b0110011;
  localparam logic [6:0] OPCODE_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;

  localparam logic [1:0] ALU_A_PC    = 2'd0;
  localparam logic [1:0] ALU_A_RS1   = 2'd1;
  localparam logic [1:0] ALU_A_OLDPC = 2'd2;
  localparam logic [1:0] ALU_A_ZERO  = 2'd3;

  localparam logic [1:0] ALU_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_B_IMM  = 2'd2;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd1;
  localparam logic [1:0] ALU_OP_CMP   = 2'd2;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
  localparam logic [1:0] WB_SEL_MDR    = 2'd1;
  localparam logic [1:0] WB_SEL_PC4    = 2'd2;

  typedef enum logic [3:0] {
    OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
    OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM, OP_BAD
  } op_class_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       oldpc_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  function automatic op_class_e classify(input logic [6:0] opc);
    case (opc)
      OPCODE_ARITH_R: return OP_R;
      OPCODE_ARITH_I: return OP_I;
      OPCODE_LOAD:    return OP_LOAD;
      OPCODE_STORE:   return OP_STORE;
      OPCODE_LUI:     return OP_LUI;
      OPCODE_AUIPC:   return OP_AUIPC;
      OPCODE_BRANCH:  return OP_BRANCH;
      OPCODE_JAL:     return OP_JAL;
      OPCODE_JALR:    return OP_JALR;
      OPCODE_SYSTEM:  return OP_SYSTEM;
      default:        return OP_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state plus opcode to the full
// datapath control vector, including the retire pulse and halted flag.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       br_taken,
  output ctrl_t      ctrl
);

  op_class_e op;

  always_comb begin
    ctrl = '0;
    op   = classify(opcode);
    case (state)
      ST_FETCH: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b0;
        if (mem_ready) begin
          // PC <= PC + 4 while IR and OldPC capture the fetched word and old PC.
          ctrl.ir_we     = 1'b1;
          ctrl.oldpc_we  = 1'b1;
          ctrl.pc_we     = 1'b1;
          ctrl.pc_src    = PC_SRC_ALU;
          ctrl.alu_src_a = ALU_A_PC;
          ctrl.alu_src_b = ALU_B_FOUR;
          ctrl.alu_op    = ALU_OP_ADD;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_a = ALU_A_OLDPC;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_EXEC: begin
        case (op)
          OP_R: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_RS2;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          OP_I: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
          end
          OP_LUI: begin
            ctrl.alu_src_a = ALU_A_ZERO;
            ctrl.alu_src_b = ALU_B_IMM;
          end
          OP_AUIPC: begin
            ctrl.alu_src_a = ALU_A_OLDPC;
            ctrl.alu_src_b = ALU_B_IMM;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a  = ALU_A_RS1;
            ctrl.alu_src_b  = ALU_B_RS2;
            ctrl.alu_op     = ALU_OP_CMP;
            ctrl.pc_we      = br_taken;
            ctrl.pc_src     = PC_SRC_ALUOUT;
            ctrl.instr_done = 1'b1;
          end
          OP_JAL: begin
            ctrl.pc_we      = 1'b1;
            ctrl.pc_src     = PC_SRC_ALUOUT;
            ctrl.reg_we     = 1'b1;
            ctrl.wb_sel     = WB_SEL_PC4;
            ctrl.instr_done = 1'b1;
          end
          OP_JALR: begin
            ctrl.alu_src_a  = ALU_A_RS1;
            ctrl.alu_src_b  = ALU_B_IMM;
            ctrl.alu_op     = ALU_OP_ADD;
            ctrl.pc_we      = 1'b1;
            ctrl.pc_src     = PC_SRC_JALR;
            ctrl.reg_we     = 1'b1;
            ctrl.wb_sel     = WB_SEL_PC4;
            ctrl.instr_done = 1'b1;
          end
          // Only reachable when SYSTEM is configured as a NOP.
          OP_SYSTEM: ctrl.instr_done = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_we       = (op == OP_STORE);
        ctrl.instr_done   = mem_ready && (op == OP_STORE);
      end
      ST_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.wb_sel     = (op == OP_LOAD) ? WB_SEL_MDR : WB_SEL_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      ST_HALT, ST_TRAP: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: state register, next-state logic and
// retired-instruction counter; outputs come from mc_ctrl_decode.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter bit HALT_ON_SYSTEM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ir,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             oldpc_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output state_e           dbg_state
);

  // Memory handshake: while mem_req is high, mem_we and mem_addr_sel are held
  // constant; the transfer completes in the cycle mem_ready is high, and only
  // then does the FSM leave FETCH/MEM. mem_ready is ignored while mem_req is low.

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  ctrl_t            ctrl;
  op_class_e        op;
  logic             unused_ir;

  assign unused_ir = ^ir[31:7];

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (ir[6:0]),
    .mem_ready (mem_ready),
    .br_taken  (br_taken),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_d       = state_q;
    retired_cnt_d = retired_cnt_q + CNT_W'(ctrl.instr_done);
    op            = classify(ir[6:0]);
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_BAD)                            state_d = ST_TRAP;
        else if (op == OP_SYSTEM && HALT_ON_SYSTEM)  state_d = ST_HALT;
        else                                         state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op)
          OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = ST_WB;
          OP_LOAD, OP_STORE:            state_d = ST_MEM;
          default:                      state_d = ST_FETCH;
        endcase
      end
      ST_MEM: if (mem_ready) state_d = (op == OP_STORE) ? ST_FETCH : ST_WB;
      ST_WB:    state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RST;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign mem_req      = ctrl.mem_req;
  assign mem_we       = ctrl.mem_we;
  assign mem_addr_sel = ctrl.mem_addr_sel;
  assign ir_we        = ctrl.ir_we;
  assign pc_we        = ctrl.pc_we;
  assign pc_src       = ctrl.pc_src;
  assign oldpc_we     = ctrl.oldpc_we;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign alu_op       = ctrl.alu_op;
  assign reg_we       = ctrl.reg_we;
  assign wb_sel       = ctrl.wb_sel;
  assign instr_done   = ctrl.instr_done;
  assign halted       = ctrl.halted;
  assign retired_cnt  = retired_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction latency, key control outputs,
// HALT/TRAP absorption and asynchronous reset mid-transfer.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = '0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, oldpc_we;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic        reg_we, instr_done, halted;
  logic [31:0] retired_cnt;
  state_e      dbg_state;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt;

  // Outputs captured in the retiring cycle, plus memory cycle counts.
  logic        s_reg_we, s_pc_we, s_mem_we;
  logic [1:0]  s_wb_sel, s_pc_src, s_a, s_b, s_op;
  int          mem_rd_cycles, mem_wr_cycles;
  int          cyc;
  logic        ret;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .oldpc_we(oldpc_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .instr_done(instr_done), .halted(halted), .retired_cnt(retired_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_latency(input string tag, input int cycles);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk(tag, 32'(cycles), e);
  endtask

  // ---------------- drivers ----------------
  // Leaves the bench at a negedge with the DUT in FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Starts at a negedge in FETCH; memory answers after nwait stall cycles.
  task automatic run_instr(input logic [31:0] instr, input int nwait, input logic bt,
                           output int cycles, output logic retired);
    int w;
    w = 0;
    cycles = 0;
    retired = 1'b0;
    mem_rd_cycles = 0;
    mem_wr_cycles = 0;
    ir = instr;
    br_taken = bt;
    for (int c = 0; c < 40; c++) begin
      mem_ready = 1'b0;
      #1;
      if (mem_req) begin
        if (w == nwait) begin
          mem_ready = 1'b1;
          w = 0;
        end else begin
          w++;
        end
        #1;
      end
      cycles++;
      if (mem_req && mem_addr_sel) begin
        if (mem_we) mem_wr_cycles++;
        else        mem_rd_cycles++;
      end
      if (instr_done) begin
        retired  = 1'b1;
        s_reg_we = reg_we;   s_wb_sel = wb_sel;
        s_pc_we  = pc_we;    s_pc_src = pc_src;
        s_a      = alu_src_a; s_b = alu_src_b; s_op = alu_op;
        s_mem_we = mem_we;
      end
      if (instr_done || halted) break;
      @(negedge clk);
    end
    if (retired) @(negedge clk);
    mem_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    exp_cnt = 0;

    // Reset: everything low even with mem_ready asserted.
    mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'(ST_RST));
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_we", 32'(ir_we), 0);
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cnt", retired_cnt, 0);

    // Release: one RST cycle, then FETCH.
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rel_state", 32'(dbg_state), 32'(ST_RST));
    @(negedge clk);
    #1;
    chk("fetch_wait_req", 32'(mem_req), 1);
    chk("fetch_wait_ir_we", 32'(ir_we), 0);
    chk("fetch_wait_pc_we", 32'(pc_we), 0);
    mem_ready = 1'b1;
    #1;
    chk("fetch_ir_we", 32'(ir_we), 1);
    chk("fetch_oldpc_we", 32'(oldpc_we), 1);
    chk("fetch_pc_we", 32'(pc_we), 1);
    chk("fetch_alu_b", 32'(alu_src_b), 1);
    chk("fetch_addr_sel", 32'(mem_addr_sel), 0);
    mem_ready = 1'b0;

    // add: 4 cycles, WB writes ALUOut.
    exp_q.push_back(4);
    run_instr(I_ADD, 0, 1'b0, cyc, ret);
    sb_latency("add_lat", cyc);
    chk("add_reg_we", 32'(s_reg_we), 1);
    chk("add_wb_sel", 32'(s_wb_sel), 0);
    exp_cnt = 1;
    chk("add_cnt", retired_cnt, exp_cnt);

    // lw with 2 wait cycles in FETCH and MEM: 9 cycles.
    exp_q.push_back(9);
    run_instr(I_LW, 2, 1'b0, cyc, ret);
    sb_latency("lw_lat", cyc);
    chk("lw_mem_rd_cycles", 32'(mem_rd_cycles), 3);
    chk("lw_reg_we", 32'(s_reg_we), 1);
    chk("lw_wb_sel", 32'(s_wb_sel), 1);
    exp_cnt = 2;
    chk("lw_cnt", retired_cnt, exp_cnt);

    // beq not taken, then taken.
    exp_q.push_back(3);
    run_instr(I_BEQ, 0, 1'b0, cyc, ret);
    sb_latency("beq_nt_lat", cyc);
    chk("beq_nt_pc_we", 32'(s_pc_we), 0);
    chk("beq_nt_alu_op", 32'(s_op), 2);
    chk("beq_nt_alu_a", 32'(s_a), 1);
    exp_q.push_back(3);
    run_instr(I_BEQ, 0, 1'b1, cyc, ret);
    sb_latency("beq_t_lat", cyc);
    chk("beq_t_pc_we", 32'(s_pc_we), 1);
    chk("beq_t_pc_src", 32'(s_pc_src), 1);
    exp_cnt = 4;
    chk("beq_cnt", retired_cnt, exp_cnt);

    // jalr: retires in EXEC with link write and masked target.
    exp_q.push_back(3);
    run_instr(I_JALR, 0, 1'b0, cyc, ret);
    sb_latency("jalr_lat", cyc);
    chk("jalr_pc_we", 32'(s_pc_we), 1);
    chk("jalr_pc_src", 32'(s_pc_src), 2);
    chk("jalr_reg_we", 32'(s_reg_we), 1);
    chk("jalr_wb_sel", 32'(s_wb_sel), 2);
    chk("jalr_alu_b", 32'(s_b), 2);
    #1;
    chk("jalr_next_state", 32'(dbg_state), 32'(ST_FETCH));

    // sw, lui, auipc, jal.
    exp_q.push_back(4);
    run_instr(I_SW, 0, 1'b0, cyc, ret);
    sb_latency("sw_lat", cyc);
    chk("sw_mem_we", 32'(s_mem_we), 1);
    chk("sw_wr_cycles", 32'(mem_wr_cycles), 1);
    exp_q.push_back(4);
    run_instr(I_LUI, 0, 1'b0, cyc, ret);
    sb_latency("lui_lat", cyc);
    exp_q.push_back(4);
    run_instr(I_AUIPC, 0, 1'b0, cyc, ret);
    sb_latency("auipc_lat", cyc);
    chk("auipc_wb_sel", 32'(s_wb_sel), 0);
    exp_q.push_back(3);
    run_instr(I_JAL, 0, 1'b0, cyc, ret);
    sb_latency("jal_lat", cyc);
    chk("jal_pc_src", 32'(s_pc_src), 1);
    chk("jal_wb_sel", 32'(s_wb_sel), 2);
    exp_cnt = 9;
    chk("mix_cnt", retired_cnt, exp_cnt);

    // Unknown opcode: TRAP after DECODE, frozen for 20 cycles.
    exp_q.push_back(3);
    run_instr(I_BAD, 0, 1'b0, cyc, ret);
    sb_latency("trap_lat", cyc);
    chk("trap_retired", 32'(ret), 0);
    chk("trap_state", 32'(dbg_state), 32'(ST_TRAP));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("trap_halted", 32'(halted), 1);
      chk("trap_cnt", retired_cnt, exp_cnt);
      chk("trap_req", 32'(mem_req), 0);
    end

    // ECALL: HALT, nothing retires.
    do_reset();
    exp_cnt = 0;
    chk("halt_rst_cnt", retired_cnt, exp_cnt);
    exp_q.push_back(3);
    run_instr(I_ECALL, 0, 1'b0, cyc, ret);
    sb_latency("ecall_lat", cyc);
    chk("ecall_state", 32'(dbg_state), 32'(ST_HALT));
    chk("ecall_halted", 32'(halted), 1);
    @(negedge clk); #1;
    chk("ecall_cnt", retired_cnt, exp_cnt);

    // Reset mid-MEM: mem_req drops before the next edge.
    do_reset();
    exp_q.push_back(4);
    run_instr(I_ADD, 0, 1'b0, cyc, ret);
    sb_latency("add2_lat", cyc);
    chk("add2_cnt", retired_cnt, 1);
    ir = I_LW;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_mem_state", 32'(dbg_state), 32'(ST_MEM));
    chk("mid_mem_req", 32'(mem_req), 1);
    chk("mid_mem_addr_sel", 32'(mem_addr_sel), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(mem_req), 0);
    chk("async_cnt_clr", retired_cnt, 0);
    chk("async_state", 32'(dbg_state), 32'(ST_RST));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_state", 32'(dbg_state), 32'(ST_RST));
    chk("post_rst_req", 32'(mem_req), 0);
    @(negedge clk);
    #1;
    chk("post_rst_fetch", 32'(dbg_state), 32'(ST_FETCH));
    chk("post_rst_fetch_req", 32'(mem_req), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
